// File: rtl/fmul_arbiter.sv
// Round-robin arbiter sharing one registered Q8.8 multiplier among NREQ requesters.
// Define FMUL_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no rotation pointer).
module fmul_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 16,
    parameter int MUL_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    input  logic [W-1:0]      mul_p,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_p,
    output logic              busy
);

    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] gnt_id;
    logic            gnt_any;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;

    logic [MUL_LAT:0] vld_p;
    logic [ID_W-1:0]  id_p [MUL_LAT+1];

`ifdef FMUL_ARB_FIXED_PRIO_EN
    always_comb begin
        grant   = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                gnt_any = 1'b1;
                gnt_id  = ID_W'(i);
            end
        end
        if (gnt_any) grant[gnt_id] = 1'b1;
    end
`else
    logic [ID_W-1:0] ptr;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return ID_W'(s);
    endfunction

    // Descending scan so the candidate closest to ptr is the last one written.
    always_comb begin
        grant   = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_add(ptr, k)]) begin
                gnt_any = 1'b1;
                gnt_id  = wrap_add(ptr, k);
            end
        end
        if (gnt_any) grant[gnt_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ptr <= '0;
        else if (gnt_any) ptr <= wrap_add(gnt_id, 1);
    end
`endif

    assign req_ready = rst_n ? grant : '0;
    assign sel_a     = req_a[int'(gnt_id)*W +: W];
    assign sel_b     = req_b[int'(gnt_id)*W +: W];
    assign busy      = |vld_p;

    // p0: operand register into fmul; tag stages advance in lockstep with fmul latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a     <= '0;
            mul_b     <= '0;
            vld_p     <= '0;
            rsp_valid <= '0;
        end else begin
            if (gnt_any) begin
                mul_a <= sel_a;
                mul_b <= sel_b;
            end
            vld_p[0] <= gnt_any;
            for (int s = 1; s <= MUL_LAT; s++) vld_p[s] <= vld_p[s-1];
            rsp_valid <= '0;
            if (vld_p[MUL_LAT]) rsp_valid[id_p[MUL_LAT]] <= 1'b1;
        end
    end

    // Tag ids and result data carry no reset; their validity comes from vld_p.
    always_ff @(posedge clk) begin
        id_p[0] <= gnt_id;
        for (int s = 1; s <= MUL_LAT; s++) id_p[s] <= id_p[s-1];
        if (vld_p[MUL_LAT]) rsp_p <= mul_p;
    end

endmodule

// File: tb/tb_fmul_arbiter.sv
// Scoreboard bench for fmul_arbiter with a behavioural registered Q8.8 multiplier.
module tb_fmul_arbiter;

    localparam int NREQ    = 4;
    localparam int W       = 16;
    localparam int MUL_LAT = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a = '0;
    logic [NREQ*W-1:0] req_b = '0;
    logic [W-1:0]      mul_a, mul_b;
    logic [W-1:0]      mul_p = '0;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_p;
    logic              busy;

    always #5 clk = ~clk;

    fmul_arbiter #(.NREQ(NREQ), .W(W), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .rsp_valid(rsp_valid), .rsp_p(rsp_p), .busy(busy)
    );

    function automatic logic [W-1:0] q88(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] p;
        p = $signed(a) * $signed(b);
        return p[W+7:8];
    endfunction

    always @(posedge clk) mul_p <= q88(mul_a, mul_b);

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int          id;
        logic [W-1:0] p;
        int          due;
    } ent_t;

    ent_t         sb[$];
    ent_t         rsp_log[$];
    int           gnt_log[$];
    int           cyc = 0;
    int           tb_ptr = 0;
    logic [W-1:0] exp_a = '0;
    logic [W-1:0] exp_b = '0;

    function automatic logic [NREQ-1:0] exp_grant(input logic [NREQ-1:0] v, input int p);
        logic [NREQ-1:0] g;
        int idx;
        g = '0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef FMUL_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = (p + k) % NREQ;
`endif
            if (v[idx] && g == '0) g[idx] = 1'b1;
        end
        return g;
    endfunction

    // Monitor: outputs are stable at the falling edge; transfers seen here commit on the next rising edge.
    always @(negedge clk) begin
        logic [NREQ-1:0] g;
        logic            bexp;
        int              rid;
        ent_t            e;
        cyc++;
        if (!rst_n) begin
            sb.delete();
            tb_ptr = 0;
            exp_a  = '0;
            exp_b  = '0;
            check("rst_ready", 32'(req_ready), 0);
            check("rst_rsp_valid", 32'(rsp_valid), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_mul_a", 32'(mul_a), 0);
        end else begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                check("rsp_valid", 32'(rsp_valid), 32'(1) << e.id);
                check("rsp_p", 32'(rsp_p), 32'(e.p));
                rid = -1;
                for (int i = 0; i < NREQ; i++) if (rsp_valid[i]) rid = i;
                rsp_log.push_back('{rid, rsp_p, cyc});
            end else begin
                check("rsp_idle", 32'(rsp_valid), 0);
            end
            bexp = 1'b0;
            foreach (sb[i]) if (sb[i].due > cyc && sb[i].due <= cyc + 2) bexp = 1'b1;
            check("busy", 32'(busy), 32'(bexp));
            check("mul_a", 32'(mul_a), 32'(exp_a));
            check("mul_b", 32'(mul_b), 32'(exp_b));
            g = exp_grant(req_valid, tb_ptr);
            check("req_ready", 32'(req_ready), 32'(g));
            for (int i = 0; i < NREQ; i++) begin
                if (g[i]) begin
                    exp_a = req_a[i*W +: W];
                    exp_b = req_b[i*W +: W];
                    sb.push_back('{i, q88(exp_a, exp_b), cyc + MUL_LAT + 2});
                    tb_ptr = (i + 1) % NREQ;
                    gnt_log.push_back(i);
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic clear_logs();
        gnt_log.delete();
        rsp_log.delete();
    endtask

    // Each requester drops valid once granted; bounded so a stuck arbiter cannot hang the run.
    task automatic hold_until_granted(input int bound);
        logic [NREQ-1:0] g;
        for (int i = 0; i < bound && req_valid != '0; i++) begin
            @(negedge clk);
            g = req_ready;
            @(posedge clk);
            #1 req_valid = req_valid & ~g;
        end
        if (req_valid != '0) begin
            check("grant_timeout", 32'(req_valid), 0);
            req_valid = '0;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Continuous demand from all four requesters
        @(posedge clk); #1;
        clear_logs();
        set_req(0, 16'h0180, 16'h0200);
        set_req(1, 16'h0100, 16'h0280);
        set_req(2, 16'hff00, 16'h0300);
        set_req(3, 16'h0440, 16'h0100);
        req_valid = 4'b1111;
        repeat (5) @(posedge clk);
        #1 req_valid = '0;
        repeat (4) @(posedge clk);
        #1;
        check("rot_n_grants", gnt_log.size(), 5);
        check("rot_n_rsp", rsp_log.size(), 5);
`ifndef FMUL_ARB_FIXED_PRIO_EN
        if (gnt_log.size() == 5) begin
            for (int i = 0; i < 5; i++) check("rot_order", gnt_log[i], i % NREQ);
        end
`endif
        if (rsp_log.size() > 0) begin
            check("rot_first_id", rsp_log[0].id, 0);
            check("rot_first_p", 32'(rsp_log[0].p), 32'h0300);
        end

        // Single request from requester 0
        clear_logs();
        set_req(0, 16'h0200, 16'h0300);
        req_valid = 4'b0001;
        @(posedge clk);
        #1 req_valid = '0;
        repeat (4) @(posedge clk);
        #1;
        check("single_n", rsp_log.size(), 1);
        if (rsp_log.size() > 0) begin
            check("single_id", rsp_log[0].id, 0);
            check("single_p", 32'(rsp_log[0].p), 32'h0600);
        end

        // Steer pointer to 2 via requester 1, then contend 1 against 3
        set_req(1, 16'h0300, 16'h0100);
        req_valid = 4'b0010;
        hold_until_granted(4);
        clear_logs();
        set_req(3, 16'h0200, 16'h0200);
        req_valid = 4'b1010;
        hold_until_granted(6);
        repeat (4) @(posedge clk);
        #1;
        check("pair_n", gnt_log.size(), 2);
        if (gnt_log.size() == 2) begin
`ifdef FMUL_ARB_FIXED_PRIO_EN
            check("pair_first", gnt_log[0], 1);
            check("pair_second", gnt_log[1], 3);
`else
            check("pair_first", gnt_log[0], 3);
            check("pair_second", gnt_log[1], 1);
`endif
        end

        // Back-to-back issues from requester 2
        clear_logs();
        set_req(2, 16'h0b00, 16'h1000);
        req_valid = 4'b0100;
        @(posedge clk);
        #1 set_req(2, 16'h0100, 16'h0100);
        @(posedge clk);
        #1 req_valid = '0;
        repeat (4) @(posedge clk);
        #1;
        check("b2b_n", rsp_log.size(), 2);
        if (rsp_log.size() == 2) begin
            check("b2b_id0", rsp_log[0].id, 2);
            check("b2b_p0", 32'(rsp_log[0].p), 32'hb000);
            check("b2b_id1", rsp_log[1].id, 2);
            check("b2b_p1", 32'(rsp_log[1].p), 32'h0100);
            check("b2b_gap", rsp_log[1].due - rsp_log[0].due, 1);
        end

        // Reset one cycle after an issue; pointer left at 2 beforehand
        clear_logs();
        set_req(1, 16'h0500, 16'h0200);
        req_valid = 4'b0010;
        @(posedge clk);
        #1 req_valid = '0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_busy", 32'(busy), 0);
        check("rstmid_mul_a", 32'(mul_a), 0);
        check("rstmid_mul_b", 32'(mul_b), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rstmid_no_rsp", rsp_log.size(), 0);
        set_req(1, 16'h0100, 16'h0700);
        set_req(3, 16'h0280, 16'h0100);
        req_valid = 4'b1010;
        hold_until_granted(6);
        repeat (4) @(posedge clk);
        #1;
        if (gnt_log.size() > 0) check("post_rst_first", gnt_log[0], 1);
        else check("post_rst_grants", gnt_log.size(), 2);

        // Idle for ten cycles
        clear_logs();
        repeat (10) @(posedge clk);
        #1;
        check("idle_grants", gnt_log.size(), 0);
        check("idle_ready", 32'(req_ready), 0);
        check("idle_busy", 32'(busy), 0);
        check("idle_mul_a", 32'(mul_a), 32'h0280);
        check("idle_mul_b", 32'(mul_b), 32'h0100);

        check("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
